// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the fetch (IF) and data (DM) requesters.
// DM wins by default; a run counter bounds how long a waiting fetch can be held off.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_DM_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned      CNT_W   = 4;
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DM_RUN);

  logic [CNT_W-1:0]   run_cnt;
  logic [MEM_LAT-1:0] tag_vld;
  logic [MEM_LAT-1:0] tag_dm;
  logic               dm_rd;
  logic               ret_vld;
  logic               ret_dm;

  // Grant is decided in the request cycle; nothing is granted while in reset.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst) begin
      if (dm_req && !(if_req && run_cnt == RUN_MAX)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  assign mem_en   = if_gnt | dm_gnt;
  assign mem_we   = dm_gnt & dm_we;
  assign dm_rd    = dm_gnt & ~dm_we;
  assign if_stall = rst & if_req & ~if_gnt;

  // Counts consecutive DM wins over a waiting fetch; saturates at the forcing threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      run_cnt <= '0;
    end else if (dm_gnt && run_cnt < RUN_MAX) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  // Tag shift register: bit 0 is loaded at the grant edge, bit MEM_LAT-1 marks the return cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      tag_dm  <= '0;
    end else begin
      tag_vld <= MEM_LAT'({tag_vld, if_gnt | dm_rd});
      tag_dm  <= MEM_LAT'({tag_dm, dm_rd});
    end
  end

  assign ret_vld   = tag_vld[MEM_LAT-1];
  assign ret_dm    = tag_dm[MEM_LAT-1];
  assign if_rvalid = ret_vld & ~ret_dm;
  assign dm_rvalid = ret_vld & ret_dm;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3 share one stimulus,
// each backed by its own latency memory model.
module tb_mem_port_arbiter;

  localparam int NL      = 3;
  localparam int MAX_RUN = 4;

  typedef struct {
    int          due;
    logic        dm;
    logic [15:0] data;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [11:0] dm_addr;
  logic [15:0] dm_wdata;

  logic        if_gnt    [NL];
  logic        if_rvalid [NL];
  logic [15:0] if_rdata  [NL];
  logic        dm_gnt    [NL];
  logic        dm_rvalid [NL];
  logic [15:0] dm_rdata  [NL];
  logic        if_stall  [NL];
  logic        mem_en    [NL];
  logic        mem_we    [NL];
  logic [11:0] mem_addr  [NL];
  logic [15:0] mem_wdata [NL];
  logic [15:0] mem_rdata [NL];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  ret_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input logic [11:0] a);
    return {a, 4'h0} ^ 16'hA5E5;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int unsigned LAT = g + 1;
    logic [15:0] mem  [4096];
    logic [15:0] pipe [LAT];

    initial for (int a = 0; a < 4096; a++) mem[a] = init_word(12'(a));

    // Memory samples the strobe at the edge ending the grant cycle; data shows LAT cycles later.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 16'hDEAD;
      for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];

    mem_port_arbiter #(
      .ADDR_W(12), .DATA_W(16), .MEM_LAT(LAT), .MAX_DM_RUN(MAX_RUN)
    ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt[g]), .dm_rvalid(dm_rvalid[g]), .dm_rdata(dm_rdata[g]),
      .if_stall(if_stall[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
  end

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 12'h003;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h007; dm_wdata = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        checks++;
        if ({if_gnt[l], dm_gnt[l], if_rvalid[l], dm_rvalid[l], if_stall[l], mem_en[l], mem_we[l]} !== 7'b0 ||
            if_rdata[l] !== 16'h0 || dm_rdata[l] !== 16'h0 || mem_addr[l] !== 12'h0 || mem_wdata[l] !== 16'h0) begin
          failures++;
          $display("FAIL reset lane%0d c%0d: gnt=%b%b rv=%b%b stall=%b en=%b we=%b addr=%h wdata=%h, expected all zero",
                   l, c, if_gnt[l], dm_gnt[l], if_rvalid[l], dm_rvalid[l], if_stall[l], mem_en[l], mem_we[l],
                   mem_addr[l], mem_wdata[l]);
        end
      end
      step();
      rst = 1'b1;
      idle_inputs();
    end
  endtask

  task automatic test_if_read();
    ret_t        e;
    logic        eiv, edv;
    logic [15:0] eid, edd;
    for (int c = 0; c < 3; c++) begin
      step();
      idle_inputs();
      if (c == 0) begin
        if_req = 1'b1; if_addr = 12'h004;
        e.due = cyc + 1; e.dm = 1'b0; e.data = 16'hA5A5;
        exp_q.push_back(e);
      end
      @(negedge clk);
      checks++;
      if (if_gnt[0] !== (c == 0) || dm_gnt[0] !== 1'b0 || mem_en[0] !== (c == 0) ||
          mem_addr[0] !== ((c == 0) ? 12'h004 : 12'h000) || if_stall[0] !== 1'b0) begin
        failures++;
        $display("FAIL if_read_gnt c%0d: if_gnt=%b dm_gnt=%b en=%b addr=%h stall=%b, expected if_gnt=%b addr=004 on c0",
                 c, if_gnt[0], dm_gnt[0], mem_en[0], mem_addr[0], if_stall[0], c == 0);
      end
      {eiv, edv, eid, edd} = '0;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.dm) begin edv = 1'b1; edd = e.data; end else begin eiv = 1'b1; eid = e.data; end
      end
      checks++;
      if (if_rvalid[0] !== eiv || if_rdata[0] !== eid || dm_rvalid[0] !== edv || dm_rdata[0] !== edd) begin
        failures++;
        $display("FAIL if_read_ret c%0d: if %b/%h dm %b/%h, expected if %b/%h dm %b/%h",
                 c, if_rvalid[0], if_rdata[0], dm_rvalid[0], dm_rdata[0], eiv, eid, edv, edd);
      end
    end
  endtask

  task automatic test_write_read();
    ret_t        e;
    logic        eiv, edv;
    logic [15:0] eid, edd;
    for (int c = 0; c < 4; c++) begin
      step();
      idle_inputs();
      if (c < 2) begin
        dm_req = 1'b1; dm_addr = 12'h010; dm_we = (c == 0); dm_wdata = 16'h1234;
      end
      if (c == 1) begin
        e.due = cyc + 1; e.dm = 1'b1; e.data = 16'h1234;
        exp_q.push_back(e);
      end
      @(negedge clk);
      checks++;
      if (dm_gnt[0] !== (c < 2) || mem_we[0] !== (c == 0) ||
          (c == 0 && (mem_addr[0] !== 12'h010 || mem_wdata[0] !== 16'h1234))) begin
        failures++;
        $display("FAIL write_read_gnt c%0d: dm_gnt=%b we=%b addr=%h wdata=%h, expected dm_gnt=%b we=%b addr=010 wdata=1234",
                 c, dm_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0], c < 2, c == 0);
      end
      {eiv, edv, eid, edd} = '0;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.dm) begin edv = 1'b1; edd = e.data; end else begin eiv = 1'b1; eid = e.data; end
      end
      checks++;
      if (if_rvalid[0] !== eiv || if_rdata[0] !== eid || dm_rvalid[0] !== edv || dm_rdata[0] !== edd) begin
        failures++;
        $display("FAIL write_read_ret c%0d: if %b/%h dm %b/%h, expected if %b/%h dm %b/%h",
                 c, if_rvalid[0], if_rdata[0], dm_rvalid[0], dm_rdata[0], eiv, eid, edv, edd);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [9:0] exp_dm = 10'b0111101111;
    for (int c = 0; c < 10; c++) begin
      step();
      if_req = 1'b1; if_addr = 12'h100;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h200;
      @(negedge clk);
      checks++;
      if (dm_gnt[0] !== exp_dm[c] || if_gnt[0] !== !exp_dm[c] || if_stall[0] !== exp_dm[c] ||
          mem_addr[0] !== (exp_dm[c] ? 12'h200 : 12'h100) || mem_we[0] !== 1'b0) begin
        failures++;
        $display("FAIL arbitration c%0d: if_gnt=%b dm_gnt=%b stall=%b addr=%h we=%b, expected dm_gnt=%b",
                 c, if_gnt[0], dm_gnt[0], if_stall[0], mem_addr[0], mem_we[0], exp_dm[c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      step();
      idle_inputs();
    end
  endtask

  task automatic test_alternating();
    ret_t        e;
    logic        eiv, edv;
    logic [15:0] eid, edd;
    for (int c = 0; c < 10; c++) begin
      step();
      idle_inputs();
      if (c < 6) begin
        e.due = cyc + 3;
        e.dm  = c[0];
        if (c[0]) begin
          dm_req = 1'b1; dm_addr = 12'(12'h040 + c); e.data = init_word(dm_addr);
        end else begin
          if_req = 1'b1; if_addr = 12'(12'h020 + c); e.data = init_word(if_addr);
        end
        exp_q.push_back(e);
      end
      @(negedge clk);
      checks++;
      if (if_gnt[2] !== (c < 6 && !c[0]) || dm_gnt[2] !== (c < 6 && c[0])) begin
        failures++;
        $display("FAIL alternating_gnt c%0d: if_gnt=%b dm_gnt=%b, expected %b %b",
                 c, if_gnt[2], dm_gnt[2], c < 6 && !c[0], c < 6 && c[0]);
      end
      {eiv, edv, eid, edd} = '0;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.dm) begin edv = 1'b1; edd = e.data; end else begin eiv = 1'b1; eid = e.data; end
      end
      checks++;
      if (if_rvalid[2] !== eiv || if_rdata[2] !== eid || dm_rvalid[2] !== edv || dm_rdata[2] !== edd) begin
        failures++;
        $display("FAIL alternating_ret c%0d: if %b/%h dm %b/%h, expected if %b/%h dm %b/%h",
                 c, if_rvalid[2], if_rdata[2], dm_rvalid[2], dm_rdata[2], eiv, eid, edv, edd);
      end
    end
  endtask

  task automatic test_reset_inflight();
    step();
    idle_inputs();
    if_req = 1'b1; if_addr = 12'h030;
    @(negedge clk);
    checks++;
    if (if_gnt[1] !== 1'b1) begin
      failures++;
      $display("FAIL inflight_gnt: if_gnt=%b, expected 1", if_gnt[1]);
    end
    step();
    rst = 1'b0;
    dm_req = 1'b1; dm_addr = 12'h031;
    @(negedge clk);
    checks++;
    if ({if_gnt[1], dm_gnt[1], if_rvalid[1], dm_rvalid[1], if_stall[1], mem_en[1], mem_we[1]} !== 7'b0 ||
        if_rdata[1] !== 16'h0 || dm_rdata[1] !== 16'h0 || mem_addr[1] !== 12'h0 || mem_wdata[1] !== 16'h0) begin
      failures++;
      $display("FAIL inflight_reset: gnt=%b%b rv=%b%b stall=%b en=%b addr=%h, expected all zero",
               if_gnt[1], dm_gnt[1], if_rvalid[1], dm_rvalid[1], if_stall[1], mem_en[1], mem_addr[1]);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      for (int l = 1; l < NL; l++) begin
        checks++;
        if (if_rvalid[l] !== 1'b0 || dm_rvalid[l] !== 1'b0 || if_rdata[l] !== 16'h0 || dm_rdata[l] !== 16'h0) begin
          failures++;
          $display("FAIL inflight_drop lane%0d c%0d: if %b/%h dm %b/%h, expected no return",
                   l, c, if_rvalid[l], if_rdata[l], dm_rvalid[l], dm_rdata[l]);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int   wait_cnt = 0;
    int   obs_run  = 0;
    int   obs_max  = 0;
    logic exp_if;
    for (int c = 0; c < 48; c++) begin
      step();
      if_req = 1'b1; if_addr = 12'h300;
      dm_req = (c < 12) ? 1'b1 : ($urandom_range(3, 0) != 0);
      dm_we = 1'b1; dm_addr = 12'(12'h800 + c); dm_wdata = 16'($urandom);
      exp_if = !dm_req || (wait_cnt == MAX_RUN);
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        checks++;
        if (if_gnt[l] !== exp_if || dm_gnt[l] !== !exp_if || if_stall[l] !== !exp_if || mem_we[l] !== !exp_if) begin
          failures++;
          $display("FAIL starvation lane%0d c%0d: if_gnt=%b dm_gnt=%b stall=%b we=%b, expected if_gnt=%b (waited %0d)",
                   l, c, if_gnt[l], dm_gnt[l], if_stall[l], mem_we[l], exp_if, wait_cnt);
        end
      end
      wait_cnt = exp_if ? 0 : wait_cnt + 1;
      obs_run  = if_stall[0] ? obs_run + 1 : 0;
      if (obs_run > obs_max) obs_max = obs_run;
    end
    checks++;
    if (obs_max > MAX_RUN) begin
      failures++;
      $display("FAIL starvation_bound: longest if_stall run=%0d, expected <= %0d", obs_max, MAX_RUN);
    end
    step();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_if_read();
    test_write_read();
    test_arbitration();
    test_alternating();
    test_reset_inflight();
    test_starvation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
